// File: rtl/hdlc_deframer.sv
// HDLC deframer: delimits frames on detector flag pulses, removes zero-stuffing,
// assembles LSB-first bytes and reports frame end, abort and overflow.
module hdlc_deframer #(
  parameter int unsigned MAX_BYTES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       w,
  input  logic       flag,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       sof,
  output logic       eof,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BCW = $clog2(MAX_BYTES + 1);

  typedef enum logic {HUNT, RX} state_t;

  state_t           state_q;
  logic [7:0]       dbit_q;
  logic [7:0]       dvld_q;
  logic [2:0]       ones_q;
  logic [2:0]       bit_cnt_q;
  logic [BCW-1:0]   byte_cnt_q;
  logic [7:0]       byte_q;
  logic [7:0]       byte_d;
  logic [7:0]       data_q;
  logic             data_valid_q;
  logic             sof_q;
  logic             eof_q;
  logic             frame_err_q;
  logic             busy_q;

  // Byte under assembly with the bit leaving the delay line placed at its slot.
  always_comb begin
    byte_d            = byte_q;
    byte_d[bit_cnt_q] = dbit_q[7];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      dbit_q       <= '0;
      dvld_q       <= '0;
      ones_q       <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      byte_q       <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      dbit_q       <= {dbit_q[6:0], w};
      dvld_q       <= {dvld_q[6:0], (state_q == RX) || flag};

      if (flag) begin
        // The flag bits occupy the whole delay line; drop them and open a frame.
        dvld_q     <= 8'h01;
        state_q    <= RX;
        busy_q     <= 1'b1;
        ones_q     <= '0;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        if (state_q == RX) begin
          if (bit_cnt_q != 3'd0) begin
            eof_q       <= 1'b1;
            frame_err_q <= 1'b1;
          end else if (byte_cnt_q != '0) begin
            eof_q <= 1'b1;
          end
        end
      end else if (state_q == RX && dvld_q[7]) begin
        if (ones_q == 3'd5) begin
          if (dbit_q[7]) begin
            // Sixth consecutive one: abort sequence.
            if (bit_cnt_q != 3'd0 || byte_cnt_q != '0) begin
              eof_q       <= 1'b1;
              frame_err_q <= 1'b1;
            end
            state_q    <= HUNT;
            busy_q     <= 1'b0;
            dvld_q     <= '0;
            ones_q     <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
          end else begin
            ones_q <= '0;
          end
        end else begin
          byte_q    <= byte_d;
          ones_q    <= dbit_q[7] ? ones_q + 3'd1 : 3'd0;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q == BCW'(MAX_BYTES)) begin
              eof_q       <= 1'b1;
              frame_err_q <= 1'b1;
              state_q     <= HUNT;
              busy_q      <= 1'b0;
            end else begin
              data_q       <= byte_d;
              data_valid_q <= 1'b1;
              sof_q        <= (byte_cnt_q == '0);
              byte_cnt_q   <= byte_cnt_q + BCW'(1);
            end
          end
        end
      end
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_hdlc_deframer.sv
// Directed bench for hdlc_deframer; a small flag detector model drives the flag input.
module tb_hdlc_deframer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       w = 1'b0;
  logic       flag = 1'b0;
  logic [7:0] hist_q = '0;

  logic [7:0] data, data2;
  logic       data_valid, sof, eof, frame_err, busy;
  logic       data_valid2, sof2, eof2, frame_err2, busy2;

  int checks = 0;
  int errors = 0;

  bit         seq [$];
  logic [7:0] o_data [64];
  logic       o_dv [64], o_sof [64], o_eof [64], o_err [64], o_busy [64];
  logic [7:0] o2_data [64];
  logic       o2_dv [64], o2_sof [64], o2_eof [64], o2_err [64], o2_busy [64];
  int n_dv, n_eof, n_dv2, n_eof2;

  hdlc_deframer dut (
    .clk(clk), .reset(reset), .w(w), .flag(flag), .data(data),
    .data_valid(data_valid), .sof(sof), .eof(eof), .frame_err(frame_err), .busy(busy)
  );

  hdlc_deframer #(.MAX_BYTES(2)) dut2 (
    .clk(clk), .reset(reset), .w(w), .flag(flag), .data(data2),
    .data_valid(data_valid2), .sof(sof2), .eof(eof2), .frame_err(frame_err2), .busy(busy2)
  );

  always #5 clk = ~clk;

  // Flag detector: pulses for the cycle after the edge that samples the closing 0.
  always @(posedge clk) begin
    hist_q <= {hist_q[6:0], w};
    flag   <= ({hist_q[6:0], w} == 8'h7E);
  end

  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) seq.push_back(v[i]);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) seq.push_back(b[i]);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    w = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_seq();
    n_dv = 0; n_eof = 0; n_dv2 = 0; n_eof2 = 0;
    for (int i = 0; i < seq.size() && i < 64; i++) begin
      w = seq[i];
      @(posedge clk);
      #1;
      o_data[i] = data;   o_dv[i] = data_valid;   o_sof[i] = sof;
      o_eof[i] = eof;     o_err[i] = frame_err;   o_busy[i] = busy;
      o2_data[i] = data2; o2_dv[i] = data_valid2; o2_sof[i] = sof2;
      o2_eof[i] = eof2;   o2_err[i] = frame_err2; o2_busy[i] = busy2;
      if (data_valid) n_dv++;
      if (eof) n_eof++;
      if (data_valid2) n_dv2++;
      if (eof2) n_eof2++;
    end
    seq.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (data !== 8'h00)    begin errors++; $display("FAIL reset_data got %h exp 00", data); end
    checks++; if (data_valid !== 0)  begin errors++; $display("FAIL reset_dv got %b exp 0", data_valid); end
    checks++; if (sof !== 0)         begin errors++; $display("FAIL reset_sof got %b exp 0", sof); end
    checks++; if (eof !== 0)         begin errors++; $display("FAIL reset_eof got %b exp 0", eof); end
    checks++; if (frame_err !== 0)   begin errors++; $display("FAIL reset_err got %b exp 0", frame_err); end
    checks++; if (busy !== 0)        begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_single_byte();
    apply_reset();
    push_byte(8'h7E); push_byte(8'hA5); push_byte(8'h7E); push_bits(16'h0, 2);
    run_seq();
    checks++; if (o_busy[7] !== 0)     begin errors++; $display("FAIL a5_busy_pre got %b exp 0", o_busy[7]); end
    checks++; if (o_busy[8] !== 1)     begin errors++; $display("FAIL a5_busy got %b exp 1", o_busy[8]); end
    checks++; if (o_dv[23] !== 1)      begin errors++; $display("FAIL a5_dv got %b exp 1", o_dv[23]); end
    checks++; if (o_data[23] !== 8'hA5) begin errors++; $display("FAIL a5_data got %h exp a5", o_data[23]); end
    checks++; if (o_sof[23] !== 1)     begin errors++; $display("FAIL a5_sof got %b exp 1", o_sof[23]); end
    checks++; if (o_eof[24] !== 1)     begin errors++; $display("FAIL a5_eof got %b exp 1", o_eof[24]); end
    checks++; if (o_err[24] !== 0)     begin errors++; $display("FAIL a5_err got %b exp 0", o_err[24]); end
    checks++; if (n_dv !== 1)          begin errors++; $display("FAIL a5_ndv got %0d exp 1", n_dv); end
    checks++; if (n_eof !== 1)         begin errors++; $display("FAIL a5_neof got %0d exp 1", n_eof); end
  endtask

  task automatic test_stuffing();
    apply_reset();
    push_byte(8'h7E); push_bits(16'h01DF, 9); push_bits(16'h00BE, 9); push_byte(8'h7E); push_bits(16'h0, 2);
    run_seq();
    checks++; if (o_dv[24] !== 1)       begin errors++; $display("FAIL stuff_dv0 got %b exp 1", o_dv[24]); end
    checks++; if (o_data[24] !== 8'hFF) begin errors++; $display("FAIL stuff_data0 got %h exp ff", o_data[24]); end
    checks++; if (o_sof[24] !== 1)      begin errors++; $display("FAIL stuff_sof0 got %b exp 1", o_sof[24]); end
    checks++; if (o_dv[33] !== 1)       begin errors++; $display("FAIL stuff_dv1 got %b exp 1", o_dv[33]); end
    checks++; if (o_data[33] !== 8'h7E) begin errors++; $display("FAIL stuff_data1 got %h exp 7e", o_data[33]); end
    checks++; if (o_sof[33] !== 0)      begin errors++; $display("FAIL stuff_sof1 got %b exp 0", o_sof[33]); end
    checks++; if (o_eof[34] !== 1 || o_err[34] !== 0) begin errors++; $display("FAIL stuff_eof got eof=%b err=%b exp 1/0", o_eof[34], o_err[34]); end
    checks++; if (n_dv !== 2)           begin errors++; $display("FAIL stuff_ndv got %0d exp 2", n_dv); end
    checks++; if (n_eof !== 1)          begin errors++; $display("FAIL stuff_neof got %0d exp 1", n_eof); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_byte(8'h7E); push_byte(8'h7E); push_byte(8'h7E); push_bits(16'h0, 2);
    run_seq();
    checks++; if (o_busy[8] !== 1)  begin errors++; $display("FAIL idle_busy got %b exp 1", o_busy[8]); end
    checks++; if (o_busy[25] !== 1) begin errors++; $display("FAIL idle_busy_end got %b exp 1", o_busy[25]); end
    checks++; if (n_dv !== 0)       begin errors++; $display("FAIL idle_ndv got %0d exp 0", n_dv); end
    checks++; if (n_eof !== 0)      begin errors++; $display("FAIL idle_neof got %0d exp 0", n_eof); end
  endtask

  task automatic test_abort();
    apply_reset();
    push_byte(8'h7E); push_byte(8'h3C); push_bits(16'h007F, 7); push_bits(16'h0, 10);
    run_seq();
    checks++; if (o_dv[23] !== 1 || o_data[23] !== 8'h3C) begin errors++; $display("FAIL abort_data got dv=%b %h exp 1/3c", o_dv[23], o_data[23]); end
    checks++; if (o_eof[28] !== 0)  begin errors++; $display("FAIL abort_eof_early got %b exp 0", o_eof[28]); end
    checks++; if (o_eof[29] !== 1)  begin errors++; $display("FAIL abort_eof got %b exp 1", o_eof[29]); end
    checks++; if (o_err[29] !== 1)  begin errors++; $display("FAIL abort_err got %b exp 1", o_err[29]); end
    checks++; if (o_busy[29] !== 0) begin errors++; $display("FAIL abort_busy got %b exp 0", o_busy[29]); end
    checks++; if (n_dv !== 1 || n_eof !== 1) begin errors++; $display("FAIL abort_counts got dv=%0d eof=%0d exp 1/1", n_dv, n_eof); end
  endtask

  task automatic test_overflow();
    apply_reset();
    push_byte(8'h7E); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_bits(16'h0, 10);
    run_seq();
    checks++; if (o2_dv[23] !== 1 || o2_data[23] !== 8'h01 || o2_sof[23] !== 1) begin errors++; $display("FAIL ovf_b0 got dv=%b %h sof=%b exp 1/01/1", o2_dv[23], o2_data[23], o2_sof[23]); end
    checks++; if (o2_dv[31] !== 1 || o2_data[31] !== 8'h02 || o2_sof[31] !== 0) begin errors++; $display("FAIL ovf_b1 got dv=%b %h sof=%b exp 1/02/0", o2_dv[31], o2_data[31], o2_sof[31]); end
    checks++; if (o2_eof[39] !== 1 || o2_err[39] !== 1) begin errors++; $display("FAIL ovf_eof got eof=%b err=%b exp 1/1", o2_eof[39], o2_err[39]); end
    checks++; if (o2_dv[39] !== 0)   begin errors++; $display("FAIL ovf_dv3 got %b exp 0", o2_dv[39]); end
    checks++; if (o2_busy[39] !== 0) begin errors++; $display("FAIL ovf_busy got %b exp 0", o2_busy[39]); end
    checks++; if (n_dv2 !== 2 || n_eof2 !== 1) begin errors++; $display("FAIL ovf_counts got dv=%0d eof=%0d exp 2/1", n_dv2, n_eof2); end
    checks++; if (n_dv !== 3 || n_eof !== 0)   begin errors++; $display("FAIL big_counts got dv=%0d eof=%0d exp 3/0", n_dv, n_eof); end
  endtask

  task automatic test_residual();
    apply_reset();
    push_byte(8'h7E); push_bits(16'h000D, 4); push_byte(8'h7E); push_bits(16'h0, 2);
    run_seq();
    checks++; if (o_eof[20] !== 1 || o_err[20] !== 1) begin errors++; $display("FAIL resid_eof got eof=%b err=%b exp 1/1", o_eof[20], o_err[20]); end
    checks++; if (n_dv !== 0 || n_eof !== 1) begin errors++; $display("FAIL resid_counts got dv=%0d eof=%0d exp 0/1", n_dv, n_eof); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    push_byte(8'h7E); push_bits(16'h0005, 3);
    run_seq();
    reset = 1'b1;
    w = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 0 || eof !== 0 || data_valid !== 0 || data !== 8'h00 || sof !== 0 || frame_err !== 0)
      begin errors++; $display("FAIL midrst_outs got busy=%b eof=%b dv=%b data=%h exp all 0", busy, eof, data_valid, data); end
    reset = 1'b0;
    push_byte(8'h7E); push_byte(8'h55); push_byte(8'h7E); push_bits(16'h0, 2);
    run_seq();
    checks++; if (o_eof[7] !== 0) begin errors++; $display("FAIL midrst_noeof got %b exp 0", o_eof[7]); end
    checks++; if (o_dv[23] !== 1 || o_data[23] !== 8'h55 || o_sof[23] !== 1) begin errors++; $display("FAIL midrst_data got dv=%b %h sof=%b exp 1/55/1", o_dv[23], o_data[23], o_sof[23]); end
    checks++; if (o_eof[24] !== 1 || o_err[24] !== 0) begin errors++; $display("FAIL midrst_eof got eof=%b err=%b exp 1/0", o_eof[24], o_err[24]); end
    checks++; if (n_dv !== 1 || n_eof !== 1) begin errors++; $display("FAIL midrst_counts got dv=%0d eof=%0d exp 1/1", n_dv, n_eof); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stuffing();
    test_back_to_back();
    test_abort();
    test_overflow();
    test_residual();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
